zx_dma_master: RTL and testbench

- Z80 bus initiator that runs alongside the A-Z80 core for snapshot and tape fast-loading.
- Requests the bus via nBUSRQ and waits for nBUSACK.
- Once granted, writes a byte stream from a valid/ready source into memory, using Z80-style write cycles that the existing ROM/RAM/SRAM decode answers unchanged.
- Periodically releases the bus so the CPU and ULA interrupt timing keep running.

---
 rtl/zx_dma_master.sv | 192 +++++++++++++++++++
 tb/tb_zx_dma_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_dma_master.sv
// Z80 bus-master DMA: requests the bus, writes a valid/ready byte stream to memory, releases periodically.
// Optional ZX_DMA_CHECKSUM_EN adds an XOR checksum output of the written bytes.
module zx_dma_master #(
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        nBUSRQ,
  input  logic        nBUSACK,
  input  logic        nWAIT,
  output logic        bus_oe,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        nMREQ,
  output logic        nRD,
  output logic        nWR,
  output logic        nIORQ
`ifdef ZX_DMA_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, REQ, FETCH, T1, T2, T3, DROP, GAP} state_e;

  state_e          state_q;
  logic [15:0]     addr_q, remain_q, burst_q;
  logic [GW-1:0]   gap_q;
  logic            final_q, abrt_q;
  logic            busy_q, done_q, aborted_q, nbusrq_q, bus_oe_q, nmreq_q, nwr_q;
  logic [15:0]     a_q;
  logic [7:0]      dout_q, ck_q;
  logic [15:0]     addr_d, remain_d, burst_d;

  assign addr_d   = addr_q + 16'd1;
  assign remain_d = remain_q - 16'd1;
  assign burst_d  = burst_q + 16'd1;

  // Single-cycle handshake: a byte is taken only in FETCH and never while aborting.
  assign src_ready = (state_q == FETCH) && src_valid && !abort;

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign nBUSRQ  = nbusrq_q;
  assign bus_oe  = bus_oe_q;
  assign A       = a_q;
  assign D_out   = dout_q;
  assign nMREQ   = nmreq_q;
  assign nWR     = nwr_q;
  assign nRD     = 1'b1;
  assign nIORQ   = 1'b1;
`ifdef ZX_DMA_CHECKSUM_EN
  assign checksum = ck_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 16'd0;
      remain_q  <= 16'd0;
      burst_q   <= 16'd0;
      gap_q     <= '0;
      final_q   <= 1'b0;
      abrt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      nbusrq_q  <= 1'b1;
      bus_oe_q  <= 1'b0;
      nmreq_q   <= 1'b1;
      nwr_q     <= 1'b1;
      a_q       <= 16'd0;
      dout_q    <= 8'd0;
      ck_q      <= 8'd0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ck_q <= 8'd0;
            if (length == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              addr_q   <= base_addr;
              remain_q <= length;
              burst_q  <= 16'd0;
              abrt_q   <= 1'b0;
              busy_q   <= 1'b1;
              nbusrq_q <= 1'b0;
              state_q  <= REQ;
            end
          end
        end
        REQ: begin
          if (abort) begin
            final_q  <= 1'b1;
            abrt_q   <= 1'b1;
            nbusrq_q <= 1'b1;
            state_q  <= DROP;
          end else if (!nBUSACK) begin
            bus_oe_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            final_q  <= 1'b1;
            abrt_q   <= 1'b1;
            bus_oe_q <= 1'b0;
            nbusrq_q <= 1'b1;
            state_q  <= DROP;
          end else if (src_valid) begin
            dout_q  <= src_data;
            a_q     <= addr_q;
            nmreq_q <= 1'b0;
            state_q <= T1;
          end
        end
        T1: begin
          nwr_q   <= 1'b0;
          state_q <= T2;
        end
        T2: begin
          if (nWAIT) begin
            nwr_q   <= 1'b1;
            nmreq_q <= 1'b1;
            state_q <= T3;
          end
        end
        T3: begin
          addr_q   <= addr_d;
          remain_q <= remain_d;
          burst_q  <= burst_d;
          ck_q     <= ck_q ^ dout_q;
          // Completion outranks abort, which outranks the burst limit.
          if (remain_d == 16'd0 || abort || burst_d == 16'(MAX_BURST)) begin
            final_q  <= (remain_d == 16'd0) || abort;
            abrt_q   <= (remain_d != 16'd0) && abort;
            bus_oe_q <= 1'b0;
            nbusrq_q <= 1'b1;
            state_q  <= DROP;
          end else begin
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (nBUSACK) begin
            if (final_q) begin
              done_q    <= 1'b1;
              aborted_q <= abrt_q;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              burst_q <= 16'd0;
              gap_q   <= '0;
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (abort) begin
            final_q <= 1'b1;
            abrt_q  <= 1'b1;
            state_q <= DROP;
          end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
            nbusrq_q <= 1'b0;
            state_q  <= REQ;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zx_dma_master.sv
// Directed table and corner-case sequences for zx_dma_master (MAX_BURST=2, GAP_CYCLES=4)
// with a two-cycle bus-grant model and a memory-write monitor.
`timescale 1ns/1ps
module tb_zx_dma_master;
  localparam int unsigned MAXB = 2;
  localparam int unsigned GAPC = 4;

  logic        clk, reset, start, abort, src_valid, nWAIT;
  logic [15:0] base_addr, length;
  logic [7:0]  src_data;
  logic        busy, done, aborted, src_ready, nBUSRQ, bus_oe, nMREQ, nRD, nWR, nIORQ;
  logic        nBUSACK, ack_pipe;
  logic [15:0] A;
  logic [7:0]  D_out;
`ifdef ZX_DMA_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  zx_dma_master #(.MAX_BURST(MAXB), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .aborted(aborted),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .nBUSRQ(nBUSRQ), .nBUSACK(nBUSACK), .nWAIT(nWAIT), .bus_oe(bus_oe),
    .A(A), .D_out(D_out), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nIORQ(nIORQ)
`ifdef ZX_DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU grant model: nBUSACK follows nBUSRQ two clocks later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_pipe <= 1'b1;
      nBUSACK  <= 1'b1;
    end else begin
      ack_pipe <= nBUSRQ;
      nBUSACK  <= ack_pipe;
    end
  end

  int n_acc, pend, ready_cnt, tenures, min_gap, rq_run, viol, lowlen, cyc, wait_left;
  logic prev_nwr = 1'b1, prev_rq = 1'b1, busy_seen;
  bit wait_inj, abort_inj;
  logic [15:0] hold_a;
  logic [7:0]  hold_d;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wl[$];
  int          wc[$];

  assign src_data = 8'((n_acc + 1) * 17);

  // Bus monitor: records each completed write, strobe/ownership violations, tenures and gaps
  always @(negedge clk) begin
    cyc++;
    if (pend != 0) n_acc++;
    pend = (src_valid && src_ready) ? 1 : 0;
    if (pend != 0) ready_cnt++;
    if (busy) busy_seen = 1'b1;
    if (bus_oe && nBUSACK) viol++;
    if (nRD !== 1'b1 || nIORQ !== 1'b1) viol++;
    if (!nBUSRQ && prev_rq) begin
      if (tenures > 0 && rq_run < min_gap) min_gap = rq_run;
      tenures++;
      rq_run = 0;
    end
    if (nBUSRQ) rq_run++;
    if (bus_oe && !nWR) begin
      if (prev_nwr) begin
        hold_a = A;
        hold_d = D_out;
      end else if (A !== hold_a || D_out !== hold_d) viol++;
      lowlen++;
    end
    if (bus_oe && nWR && !prev_nwr) begin
      wa.push_back(A); wd.push_back(D_out); wl.push_back(lowlen); wc.push_back(cyc);
      lowlen = 0;
    end
    if (wait_inj && wa.size() == 1 && bus_oe && !nWR && wait_left > 0) begin
      nWAIT = 1'b0;
      wait_left--;
    end else nWAIT = 1'b1;
    if (abort_inj && wa.size() == 1 && bus_oe && !nWR) abort = 1'b1;
    prev_nwr = nWR;
    prev_rq  = nBUSRQ;
  end

  int n_cmp, n_bad;
  logic got_ab, got_ack;
  logic [7:0] got_ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); wl.delete(); wc.delete();
    ready_cnt = 0; tenures = 0; min_gap = 1000; rq_run = 0; viol = 0;
    lowlen = 0; busy_seen = 1'b0; n_acc = 0; pend = 0;
  endtask

  task automatic run_xfer(input logic [15:0] b, input logic [15:0] len, input bit abort_on_oe,
                          output int lat);
    @(negedge clk);
    clear_mon();
    base_addr = b; length = len; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_on_oe && bus_oe) abort = 1'b1;
      if (done) begin
        lat = k; got_ab = aborted; got_ack = nBUSACK;
`ifdef ZX_DMA_CHECKSUM_EN
        got_ck = checksum;
`else
        got_ck = 8'd0;
`endif
        break;
      end
    end
    chk("done_seen", 32'(lat > 0), 1);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          n_wr;
    int          n_ten;
    logic [7:0]  ck;
  } vec_t;

  vec_t vt[5];
  int   lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b1; nWAIT = 1'b1;
    base_addr = 16'd0; length = 16'd0; wait_inj = 0; abort_inj = 0; wait_left = 0;
    clear_mon();
    vt[0] = '{16'h8000, 16'd3, 3, 2, 8'h00};
    vt[1] = '{16'hFFFE, 16'd4, 4, 2, 8'h44};
    vt[2] = '{16'h1234, 16'd5, 5, 3, 8'h11};
    vt[3] = '{16'h4000, 16'd0, 0, 0, 8'h00};
    vt[4] = '{16'h00FF, 16'd1, 1, 1, 8'h11};

    repeat (3) @(negedge clk);
    chk("rst_strobes", {nBUSRQ, bus_oe, nMREQ, nRD, nWR, nIORQ}, 6'b101111);
    chk("rst_status", {busy, done, aborted, src_ready}, 4'b0000);
    chk("rst_bus", {A, D_out}, 24'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_xfer(vt[i].base, vt[i].len, 1'b0, lat);
      chk($sformatf("v%0d_aborted", i), got_ab, 0);
      chk($sformatf("v%0d_writes", i), wa.size(), vt[i].n_wr);
      for (int j = 0; j < vt[i].n_wr && j < wa.size(); j++) begin
        chk($sformatf("v%0d_addr%0d", i, j), wa[j], 16'(vt[i].base + 16'(j)));
        chk($sformatf("v%0d_data%0d", i, j), wd[j], 8'((j + 1) * 17));
        chk($sformatf("v%0d_nwrlen%0d", i, j), wl[j], 1);
      end
      chk($sformatf("v%0d_tenures", i), tenures, vt[i].n_ten);
      if (vt[i].n_ten > 1) chk($sformatf("v%0d_gap", i), 32'(min_gap >= GAPC), 1);
      chk($sformatf("v%0d_viol", i), viol, 0);
      chk($sformatf("v%0d_ready", i), ready_cnt, 32'(vt[i].len));
      chk($sformatf("v%0d_busy_seen", i), busy_seen, 32'(vt[i].len != 0));
      if (vt[i].len == 0) chk($sformatf("v%0d_lat", i), lat, 1);
      else chk($sformatf("v%0d_ack_at_done", i), got_ack, 1);
      if (i == 0 && wc.size() >= 2) chk("v0_byte_clks", wc[1] - wc[0], 4);
`ifdef ZX_DMA_CHECKSUM_EN
      chk($sformatf("v%0d_checksum", i), got_ck, vt[i].ck);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // nWAIT low for 3 sampled edges in T2 of the second byte
    wait_inj = 1; wait_left = 3;
    run_xfer(16'h2000, 16'd3, 1'b0, lat);
    wait_inj = 0;
    chk("wait_writes", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("wait_nwr_b0", wl[0], 1);
      chk("wait_nwr_b1", wl[1], 4);
      chk("wait_addr_b1", wa[1], 16'h2001);
      chk("wait_data_b1", wd[1], 8'h22);
    end
    chk("wait_viol", viol, 0);

    // abort raised in T2 of byte 2 of 10
    abort_inj = 1;
    run_xfer(16'h3000, 16'd10, 1'b0, lat);
    abort_inj = 0; abort = 1'b0;
    chk("abt_aborted", got_ab, 1);
    chk("abt_writes", wa.size(), 2);
    chk("abt_ready", ready_cnt, 2);
    chk("abt_viol", viol, 0);

    // abort while waiting in FETCH with no source data
    src_valid = 1'b0;
    run_xfer(16'h3100, 16'd4, 1'b1, lat);
    abort = 1'b0; src_valid = 1'b1;
    chk("abtf_aborted", got_ab, 1);
    chk("abtf_writes", wa.size(), 0);
    chk("abtf_ready", ready_cnt, 0);

    // reset in the middle of T2 releases the bus at once
    @(negedge clk);
    clear_mon();
    base_addr = 16'h5000; length = 16'd3; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus_oe && !nWR) begin lat = k; break; end
    end
    chk("rst_t2_reached", 32'(lat > 0), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_bus", {bus_oe, nBUSRQ, nWR, nMREQ, busy}, 5'b01110);
    @(negedge clk);
    reset = 1'b0;

    run_xfer(16'h8000, 16'd3, 1'b0, lat);
    chk("recover_writes", wa.size(), 3);
    chk("recover_aborted", got_ab, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
